ram_dp_param: RTL and testbench

Parametrised true-dual-port synchronous RAM, successor to the fixed 2K×8 block RAM wrapper. Adds configurable width and depth, per-byte write enables, per-port enable, selectable write mode, optional output register, a defined same-address collision policy with a collision counter, and a self-clearing scrub engine. It sits between the processor core (port A, instruction/data) and peripherals/DMA (port B). It is inferred from behavioural RTL, with no vendor primitive.

---
 rtl/ram_dp_param.sv | 183 ++++++++++++++++++
 tb/tb_ram_dp_param.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/ram_dp_param.sv
// ram_dp_param: parametrised true-dual-port synchronous RAM with per-byte write
// enables, selectable write mode per port, optional output register, same-address
// collision policy with a saturating collision counter, and a scrub engine that
// zeroes the whole array.
//
// Ports:
//   clk, rst_n            clock; asynchronous active-low reset (registers only)
//   en_a/we_a/addr_a/data_a/q_a   port A: enable, byte write enables, address,
//                                 write data, read data
//   en_b/we_b/addr_b/data_b/q_b   port B: same as port A
//   clr_req               start a scrub of the entire array to zero
//   clr_busy              scrub in progress (port B blocked)
//   coll                  one-cycle pulse after a same-address collision
//   coll_cnt              saturating collision count
module ram_dp_param #(
  parameter int DW      = 8,
  parameter int AW      = 11,
  parameter int NBE     = DW / 8,
  parameter int WMODE_A = 0,
  parameter int WMODE_B = 0,
  parameter int OUT_REG = 0
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en_a,
  input  logic [NBE-1:0] we_a,
  input  logic [AW-1:0]  addr_a,
  input  logic [DW-1:0]  data_a,
  output logic [DW-1:0]  q_a,
  input  logic           en_b,
  input  logic [NBE-1:0] we_b,
  input  logic [AW-1:0]  addr_b,
  input  logic [DW-1:0]  data_b,
  output logic [DW-1:0]  q_b,
  input  logic           clr_req,
  output logic           clr_busy,
  output logic           coll,
  output logic [15:0]    coll_cnt
);

  localparam int DEPTH = 1 << AW;

  typedef enum logic {S_IDLE, S_CLEAR} scrub_state_t;

  logic [DW-1:0]    mem [DEPTH];
  scrub_state_t     state_q, state_d;
  logic [AW-1:0]    scrub_addr_q, scrub_addr_d;
  // Words written by port A since the current scrub started; the scrub skips them.
  logic [DEPTH-1:0] kept_q;

  logic             busy, b_en, wr_a, wr_b, wr_s, same_addr, coll_det;
  logic [DW-1:0]    old_a, old_b, new_a, new_b;
  logic [DW-1:0]    rd_a_p0, rd_b_p0;
  logic             coll_q;
  logic [15:0]      coll_cnt_q;

  function automatic logic [DW-1:0] lane_merge(input logic [DW-1:0]  base,
                                               input logic [DW-1:0]  data,
                                               input logic [NBE-1:0] we);
    logic [DW-1:0] m;
    m = base;
    for (int i = 0; i < NBE; i++) begin
      if (we[i]) m[8*i +: 8] = data[8*i +: 8];
    end
    return m;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  always_comb begin
    busy      = (state_q == S_CLEAR);
    b_en      = en_b & ~busy;
    wr_a      = en_a & (|we_a);
    wr_b      = b_en & (|we_b);
    same_addr = (addr_a == addr_b);
    coll_det  = en_a & b_en & same_addr & (wr_a | wr_b);
    // A port A write to the current scrub address suppresses that scrub write.
    wr_s      = busy & ~kept_q[scrub_addr_q] & ~(wr_a & (addr_a == scrub_addr_q));
    old_a     = mem[addr_a];
    old_b     = mem[addr_b];
    // Final stored word at each port's address; A is merged last so it owns shared lanes.
    new_a     = old_a;
    if (wr_b && same_addr) new_a = lane_merge(new_a, data_b, we_b);
    new_a     = lane_merge(new_a, data_a, we_a);
    new_b     = lane_merge(old_b, data_b, we_b);
    if (wr_a && same_addr) new_b = lane_merge(new_b, data_a, we_a);
  end

  // Array: no reset. When addresses coincide every writer stores the same word.
  always_ff @(posedge clk) begin
    if (wr_s) mem[scrub_addr_q] <= '0;
    if (wr_b) mem[addr_b] <= new_b;
    if (wr_a) mem[addr_a] <= new_a;
  end

  // ---- stage p0: read registers ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_a_p0 <= '0;
      rd_b_p0 <= '0;
    end else begin
      if (en_a) begin
        if (!wr_a)             rd_a_p0 <= old_a;
        else if (WMODE_A == 0) rd_a_p0 <= new_a;
        else if (WMODE_A == 1) rd_a_p0 <= old_a;
      end
      if (b_en) begin
        if (!wr_b)             rd_b_p0 <= old_b;
        else if (WMODE_B == 0) rd_b_p0 <= new_b;
        else if (WMODE_B == 1) rd_b_p0 <= old_b;
      end
    end
  end

  // ---- stage p1: optional output register, loads every cycle ----
  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [DW-1:0] rd_a_p1, rd_b_p1;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rd_a_p1 <= '0;
          rd_b_p1 <= '0;
        end else begin
          rd_a_p1 <= rd_a_p0;
          rd_b_p1 <= rd_b_p0;
        end
      end
      assign q_a = rd_a_p1;
      assign q_b = rd_b_p1;
    end else begin : g_no_out_reg
      assign q_a = rd_a_p0;
      assign q_b = rd_b_p0;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      coll_q     <= 1'b0;
      coll_cnt_q <= '0;
    end else begin
      coll_q <= coll_det;
      if (coll_det) coll_cnt_q <= sat_inc16(coll_cnt_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      scrub_addr_q <= '0;
      kept_q       <= '0;
    end else begin
      state_q      <= state_d;
      scrub_addr_q <= scrub_addr_d;
      if (state_q == S_IDLE && clr_req) kept_q <= '0;
      else if (busy && wr_a)            kept_q[addr_a] <= 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    scrub_addr_d = scrub_addr_q;
    case (state_q)
      S_IDLE: begin
        if (clr_req) begin
          state_d      = S_CLEAR;
          scrub_addr_d = '0;
        end
      end
      S_CLEAR: begin
        scrub_addr_d = scrub_addr_q + AW'(1);
        if (scrub_addr_q == '1) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign clr_busy = busy;
  assign coll     = coll_q;
  assign coll_cnt = coll_cnt_q;

endmodule

// File: tb/tb_ram_dp_param.sv
// Directed bench for ram_dp_param (DW=16, AW=4). Three instances share stimulus:
// u0 write-first/no output reg, u1 read-first/output reg, u2 no-change/no output reg.
module tb_ram_dp_param;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en_a, en_b, clr_req;
  logic [1:0]  we_a, we_b;
  logic [3:0]  addr_a, addr_b;
  logic [15:0] data_a, data_b;

  logic [15:0] q_a0, q_b0, cnt0, q_a1, q_b1, cnt1, q_a2, q_b2, cnt2;
  logic        busy0, coll0, busy1, coll1, busy2, coll2;

  int checks = 0;
  int errors = 0;
  int cnt;

  always #5 clk = ~clk;

  ram_dp_param #(.DW(16), .AW(4), .WMODE_A(0), .WMODE_B(0), .OUT_REG(0)) u0 (
    .clk(clk), .rst_n(rst_n),
    .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .data_a(data_a), .q_a(q_a0),
    .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .data_b(data_b), .q_b(q_b0),
    .clr_req(clr_req), .clr_busy(busy0), .coll(coll0), .coll_cnt(cnt0));

  ram_dp_param #(.DW(16), .AW(4), .WMODE_A(1), .WMODE_B(1), .OUT_REG(1)) u1 (
    .clk(clk), .rst_n(rst_n),
    .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .data_a(data_a), .q_a(q_a1),
    .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .data_b(data_b), .q_b(q_b1),
    .clr_req(clr_req), .clr_busy(busy1), .coll(coll1), .coll_cnt(cnt1));

  ram_dp_param #(.DW(16), .AW(4), .WMODE_A(2), .WMODE_B(2), .OUT_REG(0)) u2 (
    .clk(clk), .rst_n(rst_n),
    .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .data_a(data_a), .q_a(q_a2),
    .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .data_b(data_b), .q_b(q_b2),
    .clr_req(clr_req), .clr_busy(busy2), .coll(coll2), .coll_cnt(cnt2));

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    en_a = 1'b0; we_a = 2'b00; en_b = 1'b0; we_b = 2'b00; clr_req = 1'b0;
  endtask

  task automatic drive_a(input logic [1:0] we, input logic [3:0] addr, input logic [15:0] data);
    en_a = 1'b1; we_a = we; addr_a = addr; data_a = data;
  endtask

  task automatic drive_b(input logic [1:0] we, input logic [3:0] addr, input logic [15:0] data);
    en_b = 1'b1; we_b = we; addr_b = addr; data_b = data;
  endtask

  initial begin
    rst_n = 1'b0; idle();
    addr_a = '0; addr_b = '0; data_a = '0; data_b = '0;
    #2;
    chk("rst_q_a0", q_a0, 16'h0);   chk("rst_q_b0", q_b0, 16'h0);
    chk("rst_busy0", 16'(busy0), 16'h0); chk("rst_coll0", 16'(coll0), 16'h0);
    chk("rst_cnt0", cnt0, 16'h0);
    chk("rst_q_a1", q_a1, 16'h0);   chk("rst_q_b1", q_b1, 16'h0);
    chk("rst_busy1", 16'(busy1), 16'h0); chk("rst_coll1", 16'(coll1), 16'h0);
    chk("rst_cnt1", cnt1, 16'h0);
    chk("rst_q_a2", q_a2, 16'h0);   chk("rst_q_b2", q_b2, 16'h0);
    chk("rst_busy2", 16'(busy2), 16'h0); chk("rst_coll2", 16'(coll2), 16'h0);
    chk("rst_cnt2", cnt2, 16'h0);
    tick(); tick();
    rst_n = 1'b1;

    // 1: write A, read back through B; latency 1 vs 2
    drive_a(2'b11, 4'd3, 16'hA55A); tick();
    idle(); drive_b(2'b00, 4'd3, 16'h0); tick();
    chk("t1_q_b0", q_b0, 16'hA55A);
    chk("t1_q_b1_lat", q_b1, 16'h0);
    idle(); tick();
    chk("t1_q_b1", q_b1, 16'hA55A);

    // 2: byte-lane write and write modes on port A
    drive_a(2'b11, 4'd5, 16'h1234); tick();
    drive_a(2'b00, 4'd3, 16'h0); tick();
    drive_a(2'b01, 4'd5, 16'hFFFF); tick();
    chk("t2_wf_q_a0", q_a0, 16'h12FF);
    chk("t2_nc_q_a2", q_a2, 16'hA55A);
    drive_a(2'b00, 4'd5, 16'h0); tick();
    chk("t2_read_q_a0", q_a0, 16'h12FF);
    chk("t2_rf_q_a1", q_a1, 16'h1234);
    chk("t2_read_q_a2", q_a2, 16'h12FF);
    idle(); tick();

    // 3: both ports write address 7
    drive_a(2'b01, 4'd7, 16'h1111); drive_b(2'b11, 4'd7, 16'h2222); tick();
    chk("t3_coll", 16'(coll0), 16'h1);
    chk("t3_cnt", cnt0, 16'h1);
    chk("t3_wf_q_b0", q_b0, 16'h2211);
    chk("t3_nc_q_b2", q_b2, 16'hA55A);
    idle(); tick();
    chk("t3_coll_pulse", 16'(coll0), 16'h0);
    drive_a(2'b00, 4'd7, 16'h0); drive_b(2'b00, 4'd7, 16'h0); tick();
    chk("t3_rd_coll", 16'(coll0), 16'h0);
    chk("t3_rd_q_a0", q_a0, 16'h2211);
    chk("t3_rd_q_b0", q_b0, 16'h2211);
    idle(); tick();
    chk("t3_rd_cnt", cnt0, 16'h1);

    // 4: write/read collision and counter saturation
    drive_a(2'b11, 4'd2, 16'h00AA); tick();
    drive_a(2'b11, 4'd2, 16'hBEEF); drive_b(2'b00, 4'd2, 16'h0); tick();
    chk("t4_q_b0", q_b0, 16'h00AA);
    chk("t4_cnt", cnt0, 16'h2);
    chk("t4_coll", 16'(coll0), 16'h1);
    idle(); tick();
    force tb_ram_dp_param.u0.coll_cnt_q = 16'hFFFF;
    drive_a(2'b11, 4'd2, 16'hBEEF); drive_b(2'b00, 4'd2, 16'h0); tick();
    release tb_ram_dp_param.u0.coll_cnt_q;
    idle(); tick();
    chk("t4_sat", cnt0, 16'hFFFF);

    // 5: fill, scrub, B blocked, A write during scrub survives
    for (int i = 0; i < 16; i++) begin
      drive_a(2'b11, 4'(i), 16'h1000 + 16'(i)); tick();
    end
    idle(); clr_req = 1'b1; tick();
    clr_req = 1'b0;
    chk("t5_busy_rise", 16'(busy0), 16'h1);
    cnt = 0;
    while (busy0 && cnt < 40) begin
      drive_b(2'b11, 4'(cnt), 16'hFFFF);
      if (cnt == 2) drive_a(2'b11, 4'd15, 16'h0BAD);
      else begin en_a = 1'b0; we_a = 2'b00; end
      tick();
      cnt++;
    end
    idle();
    chk("t5_busy_cycles", 16'(cnt), 16'd16);
    chk("t5_q_b_hold", q_b0, 16'hBEEF);
    for (int i = 0; i < 16; i++) begin
      drive_b(2'b00, 4'(i), 16'h0); tick();
      chk($sformatf("t5_word%0d", i), q_b0, (i == 15) ? 16'h0BAD : 16'h0000);
    end
    idle(); tick();

    // 6: reset mid-scrub at scrub address 6
    for (int i = 0; i < 16; i++) begin
      drive_a(2'b11, 4'(i), 16'h2000 + 16'(i)); tick();
    end
    idle(); clr_req = 1'b1; tick();
    clr_req = 1'b0;
    repeat (6) tick();
    #3;
    rst_n = 1'b0;
    #1;
    chk("t6_busy", 16'(busy0), 16'h0);
    chk("t6_q_a0", q_a0, 16'h0);
    chk("t6_q_b0", q_b0, 16'h0);
    chk("t6_cnt", cnt0, 16'h0);
    chk("t6_q_a1", q_a1, 16'h0);
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      drive_b(2'b00, 4'(i), 16'h0); tick();
      chk($sformatf("t6_word%0d", i), q_b0, (i < 6) ? 16'h0000 : 16'h2000 + 16'(i));
    end
    idle(); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
